mem_initiator: RTL and testbench
================================

# mem_initiator

Initiator for the word-addressed data memory. Converts CPU load/store requests (byte/half/word, byte address) into single-cycle `re`/`we` strobes, waits on `rdy`, and returns a response. Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended. Sits between the CPU load/store stage and the memory block.

## Interface
Parameters:
- `MEM_WORDS`, 4029: words present; word index ≥ `MEM_WORDS` is an error.
- `TIMEOUT_CYCLES`, 16: wait-state cycles without `rdy` before an error response.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  high only in IDLE; request accepted on edge with `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 byte, 1 half, 2 word, 3 illegal.
- `req_signed`  in  1  load sign-extends when 1.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_rdata`  out  32  load result (0 for stores and errors).
- `resp_err`  out  1  qualifies `resp_valid`.
- `mem_re`, `mem_we`  out  1  memory strobes.
- `mem_address`  out  32  word index = `{2'b0, req_addr[31:2]}`.
- `mem_data_w`  out  32  write word.
- `mem_data_r`  in  32  read word.
- `mem_rdy`  in  1  memory completion.

## Operation
- States: IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP.
- IDLE: on accept, latch request. Error check first: `req_size`=3, half with `addr[0]`≠0, word with `addr[1:0]`≠0, or word index ≥ `MEM_WORDS` → RESP with `resp_err`=1, no memory strobe. Else load or sub-word store → RD; word store → WR.
- RD: `mem_re`=1 exactly one cycle → RD_WAIT.
- RD_WAIT: strobes low; on `mem_rdy`=1 latch `mem_data_r`; load → RESP, sub-word store → WR with merged word.
- WR: `mem_we`=1 exactly one cycle, `mem_data_w` = merged/full word → WR_WAIT.
- WR_WAIT: on `mem_rdy`=1 → RESP.
- RESP: `resp_valid`=1 one cycle → IDLE.
- Lanes little-endian: byte lane `addr[1:0]`, half lane `addr[1]`. Merge replaces only target lane with `req_wdata[7:0]`/`[15:0]`.
- Load extract: lane value zero- or sign-extended per `req_signed`; word ignores `req_signed`.
- `mem_re` and `mem_we` never high together; always ≥1 low cycle between strobes (guaranteed by WAIT states) so memory sees a rising edge per access.
- `mem_address`, `mem_data_w` held stable from RD/WR through end of matching WAIT.
- Timeout: counter cleared entering each WAIT state, increments per WAIT cycle without `mem_rdy`; at `TIMEOUT_CYCLES` → RESP, `resp_err`=1, `resp_rdata`=0; RMW aborted, no write issued.

## Timing
- Reset: state IDLE; `req_ready`=0 while `rst` high, 1 first cycle after; `mem_re`, `mem_we`, `resp_valid`, `resp_err`=0; `mem_address`, `mem_data_w`, `resp_rdata`=0.
- Acceptance edge E0. Load / word store with zero-wait memory: strobe in cycle E0+1, `mem_rdy` sampled at E0+2, `resp_valid` in cycle E0+3.
- Sub-word store: `mem_re` cycle E0+1, `mem_we` cycle E0+3, `resp_valid` cycle E0+5.
- Error-check reject: `resp_valid` cycle E0+1.
- `mem_rdy` sampled only in WAIT states; ignored elsewhere.
- Each extra memory wait cycle adds one cycle of latency.
- `rst` mid-operation: abandon, strobes low next cycle, no response emitted.

## Structure
- Shared package `mem_if_pkg`: size encodings (`SZ_BYTE/HALF/WORD`), state encoding, default `TIMEOUT_CYCLES`, `MEM_WORDS`.
- One sub-module `mem_lane_unit`: combinational lane extract/extend and store merge, reused by future instruction-fetch initiator.

## Test plan
- Word store 0xDEADBEEF to addr 0x10, word load addr 0x10 → `mem_address`=4, `resp_rdata`=0xDEADBEEF at E0+3, `resp_err`=0.
- Byte store 0xAA to addr 0x11 over word 0x11223344 → one `mem_re`, one `mem_we` with 0x1122AA44, resp at E0+5; signed byte load addr 0x11 → 0xFFFFFFAA, unsigned → 0x000000AA.
- Signed half load addr 0x12 of 0x8001_0000 → 0xFFFF8001; half load addr 0x13 → `resp_err`=1 at E0+1, no strobe.
- Word index 4029 or `req_size`=3 → `resp_err`=1, `mem_re`/`mem_we` never asserted.
- Memory model holding `mem_rdy` low → `resp_err`=1 after 16 wait cycles; sub-word store aborts with no `mem_we`.
- `rst` asserted in RD_WAIT → no `resp_valid`, strobes low, `req_ready`=1 first cycle after release.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared encodings and defaults for the data-memory initiator and its lane unit.
package mem_if_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_WR_WAIT,
    ST_RESP
  } state_e;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;
  localparam int unsigned DEF_MEM_WORDS      = 4029;

  // Alignment rule for a request; illegal size is reported as misaligned too.
  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      SZ_WORD: misaligned = |lo;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Little-endian lane extraction with sign/zero extension, and sub-word store merge.
module mem_lane_unit
  import mem_if_pkg::*;
(
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = rdata[{lane, 3'b000} +: 8];
    half_v    = rdata[{lane[1], 4'b0000} +: 16];
    load_data = '0;
    merged    = rdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & half_v[15]}}, half_v};
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SZ_WORD: begin
        load_data = rdata;
        merged    = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// CPU load/store to word-addressed memory initiator: single-cycle strobes,
// rdy handshake with timeout, read-modify-write for sub-word stores.
module mem_initiator
  import mem_if_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = DEF_MEM_WORDS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_w,
  input  logic [31:0] mem_data_r,
  input  logic        mem_rdy
);

  localparam int unsigned CW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_e      state, state_n;
  logic        accept, bad_req, timed_out;
  logic [31:0] word_idx;
  logic        we_q, signed_q, err_q;
  size_e       size_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q, rdata_q;
  logic [31:0] load_data, merged;
  logic [CW-1:0] wait_cnt;

  assign word_idx  = {2'b00, req_addr[31:2]};
  assign bad_req   = misaligned(size_e'(req_size), req_addr[1:0]) || (word_idx >= MEM_WORDS_W);
  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign timed_out = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  assign mem_re     = (state == ST_RD);
  assign mem_we     = (state == ST_WR);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

  mem_lane_unit u_lane (
    .size      (size_q),
    .sign_ext  (signed_q),
    .lane      (lane_q),
    .wdata     (wdata_q),
    .rdata     (mem_data_r),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bad_req)                                         state_n = ST_RESP;
          else if (!req_we || size_e'(req_size) != SZ_WORD)    state_n = ST_RD;
          else                                                 state_n = ST_WR;
        end
      end
      ST_RD:      state_n = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (mem_rdy)        state_n = we_q ? ST_WR : ST_RESP;
        else if (timed_out) state_n = ST_RESP;
      end
      ST_WR:      state_n = ST_WR_WAIT;
      ST_WR_WAIT: if (mem_rdy || timed_out) state_n = ST_RESP;
      ST_RESP:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= SZ_BYTE;
      lane_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_address <= '0;
      mem_data_w  <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            signed_q    <= req_signed;
            size_q      <= size_e'(req_size);
            lane_q      <= req_addr[1:0];
            wdata_q     <= req_wdata;
            err_q       <= bad_req;
            rdata_q     <= '0;
            mem_address <= word_idx;
            mem_data_w  <= req_we ? req_wdata : '0;
          end
        end
        ST_RD, ST_WR: wait_cnt <= '0;
        // RMW: the merged word replaces mem_data_w only after RD_WAIT completes,
        // so the write strobe that follows already sees it.
        ST_RD_WAIT: begin
          if (mem_rdy) begin
            if (we_q) mem_data_w <= merged;
            else      rdata_q    <= load_data;
          end else if (timed_out) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if (!mem_rdy) begin
            if (timed_out) err_q    <= 1'b1;
            else           wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: memory model with configurable latency/stall,
// scoreboard of expected responses and their due cycles.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_re, mem_we;
  logic [31:0] mem_address, mem_data_w;
  logic [31:0] mem_data_r = '0;
  logic        mem_rdy = 1'b0;

  mem_initiator #(.MEM_WORDS(4029), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_re(mem_re), .mem_we(mem_we), .mem_address(mem_address),
    .mem_data_w(mem_data_w), .mem_data_r(mem_data_r), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Memory model: rdy pulses lat_cfg cycles after the zero-wait point; hold stalls forever.
  logic [31:0] mem [0:4095];
  int   lat_cfg = 0;
  logic hold = 1'b0;
  logic busy = 1'b0;
  int   wcnt = 0;

  always @(posedge clk) begin
    mem_rdy <= 1'b0;
    if (rst || hold) busy <= 1'b0;
    if (mem_re || mem_we) begin
      if (mem_re) mem_data_r <= mem[mem_address[11:0]];
      if (mem_we) mem[mem_address[11:0]] <= mem_data_w;
      if (!hold) begin
        if (lat_cfg == 0) mem_rdy <= 1'b1;
        else begin busy <= 1'b1; wcnt <= 1; end
      end
    end else if (busy && !hold) begin
      if (wcnt >= lat_cfg) begin mem_rdy <= 1'b1; busy <= 1'b0; end
      else wcnt <= wcnt + 1;
    end
  end

  // Strobe monitor
  int          re_cnt = 0, we_cnt = 0, we_cyc = 0;
  logic [31:0] re_addr = '0, we_addr = '0, we_data = '0;
  logic        prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (mem_re || mem_we) begin
      chk("strobe_overlap", {31'b0, mem_re & mem_we}, 32'd0);
      chk("strobe_gap", {31'b0, prev_strobe}, 32'd0);
    end
    if (mem_re) begin re_cnt++; re_addr = mem_address; end
    if (mem_we) begin we_cnt++; we_addr = mem_address; we_data = mem_data_w; we_cyc = cyc; end
    prev_strobe = mem_re | mem_we;
  end

  // Scoreboard
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];
  int   resp_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      resp_cnt++;
      n_checks++;
      assert (sb.size() != 0) n_pass++;
      else $error("FAIL unexpected_resp: observed resp_valid with rdata %h err %b, required none", resp_rdata, resp_err);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        chk("resp_cycle", cyc, e.due);
      end
    end
  end

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                        input int exp_re, input int exp_we, output int e0);
    int n, re0, we0;
    re0 = re_cnt; we0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    e0 = cyc;
    req_valid = 1'b0;
    sb.push_back('{exp_rdata, exp_err, e0 + lat - 1});
    n = 0;
    while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk({tag, "_done"}, sb.size(), 32'd0);
    sb.delete();
    @(negedge clk);
    chk({tag, "_re_cnt"}, re_cnt - re0, exp_re);
    chk({tag, "_we_cnt"}, we_cnt - we0, exp_we);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, rc0;
    // Reset values
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_data_w", mem_data_w, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", {31'b0, req_ready}, 32'd1);

    // Word store / load
    do_req("sw10", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 3, 0, 1, e0);
    chk("sw10_addr", we_addr, 32'd4);
    chk("sw10_data", we_data, 32'hDEADBEEF);
    do_req("lw10", 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0, e0);
    chk("lw10_addr", re_addr, 32'd4);

    // Byte RMW and byte loads
    do_req("sw10b", 1, 2'd2, 0, 32'h10, 32'h11223344, 32'h0, 0, 3, 0, 1, e0);
    do_req("sb11", 1, 2'd0, 0, 32'h11, 32'h000000AA, 32'h0, 0, 5, 1, 1, e0);
    chk("sb11_data", we_data, 32'h1122AA44);
    chk("sb11_we_cycle", we_cyc, e0 + 2);
    do_req("lb11", 0, 2'd0, 1, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 3, 1, 0, e0);
    do_req("lbu11", 0, 2'd0, 0, 32'h11, 32'h0, 32'h000000AA, 0, 3, 1, 0, e0);
    do_req("sb13", 1, 2'd0, 0, 32'h13, 32'hFFFFFF55, 32'h0, 0, 5, 1, 1, e0);
    chk("sb13_data", we_data, 32'h5522AA44);
    do_req("lb13", 0, 2'd0, 1, 32'h13, 32'h0, 32'h00000055, 0, 3, 1, 0, e0);

    // Half RMW and half loads
    do_req("sh10", 1, 2'd1, 0, 32'h10, 32'h1234BEEF, 32'h0, 0, 5, 1, 1, e0);
    chk("sh10_data", we_data, 32'h5522BEEF);
    do_req("lhu10", 0, 2'd1, 0, 32'h10, 32'h0, 32'h0000BEEF, 0, 3, 1, 0, e0);
    do_req("lh10", 0, 2'd1, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 3, 1, 0, e0);
    do_req("sw10c", 1, 2'd2, 0, 32'h10, 32'h80010000, 32'h0, 0, 3, 0, 1, e0);
    do_req("lh12", 0, 2'd1, 1, 32'h12, 32'h0, 32'hFFFF8001, 0, 3, 1, 0, e0);
    do_req("lhu12", 0, 2'd1, 0, 32'h12, 32'h0, 32'h00008001, 0, 3, 1, 0, e0);

    // Error-check rejects: no strobes, response at E0+1
    do_req("lh13", 0, 2'd1, 1, 32'h13, 32'h0, 32'h0, 1, 1, 0, 0, e0);
    do_req("lw12", 0, 2'd2, 0, 32'h12, 32'h0, 32'h0, 1, 1, 0, 0, e0);
    do_req("ld_sz3", 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0, e0);
    do_req("st_sz3", 1, 2'd3, 0, 32'h10, 32'h1, 32'h0, 1, 1, 0, 0, e0);
    do_req("sh11", 1, 2'd1, 0, 32'h11, 32'h1, 32'h0, 1, 1, 0, 0, e0);

    // Word index boundary
    do_req("sw4028", 1, 2'd2, 0, 32'h3EF0, 32'h12345678, 32'h0, 0, 3, 0, 1, e0);
    chk("sw4028_addr", we_addr, 32'd4028);
    do_req("lw4028", 0, 2'd2, 0, 32'h3EF0, 32'h0, 32'h12345678, 0, 3, 1, 0, e0);
    do_req("lw4029", 0, 2'd2, 0, 32'h3EF4, 32'h0, 32'h0, 1, 1, 0, 0, e0);
    do_req("sw4029", 1, 2'd2, 0, 32'h3EF4, 32'h5, 32'h0, 1, 1, 0, 0, e0);
    do_req("lw_hi", 0, 2'd2, 0, 32'h80000010, 32'h0, 32'h0, 1, 1, 0, 0, e0);

    // Memory wait states add latency
    lat_cfg = 2;
    do_req("lw10_w2", 0, 2'd2, 0, 32'h10, 32'h0, 32'h80010000, 0, 5, 1, 0, e0);
    do_req("sb12_w2", 1, 2'd0, 0, 32'h12, 32'h7E, 32'h0, 0, 9, 1, 1, e0);
    chk("sb12_w2_data", we_data, 32'h807E0000);
    lat_cfg = 0;

    // Timeout: 16 stalled wait cycles, RMW aborted without write
    hold = 1'b1;
    do_req("to_load", 0, 2'd2, 0, 32'h10, 32'h0, 32'h0, 1, 18, 1, 0, e0);
    do_req("to_rmw", 1, 2'd0, 0, 32'h11, 32'h33, 32'h0, 1, 18, 1, 0, e0);
    hold = 1'b0;
    do_req("lw10_after_to", 0, 2'd2, 0, 32'h10, 32'h0, 32'h807E0000, 0, 3, 1, 0, e0);

    // Reset during RD_WAIT: no response, strobes low, ready after release
    hold = 1'b1;
    rc0 = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_re", {31'b0, mem_re}, 32'd0);
    chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    chk("midrst_rel_ready", {31'b0, req_ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("midrst_no_resp", resp_cnt - rc0, 32'd0);
    do_req("lw10_after_rst", 0, 2'd2, 0, 32'h10, 32'h0, 32'h807E0000, 0, 3, 1, 0, e0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
